// File: rtl/core_mem_seq_pkg.sv
// Shared types and constants for the core main-store sequencer.
package core_mem_seq_pkg;

  localparam int unsigned ADDR_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    CLEAR,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_READ,
    OP_WRITE,
    OP_CLEAR
  } op_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/core_mem_seq_if.sv
// Request/response bundle between the control unit and the main-store sequencer.
interface core_mem_seq_if #(
  parameter int unsigned WORD_W = 31
);
  import core_mem_seq_pkg::*;

  logic [ADDR_W-1:0] sel_value_from_sel;
  logic              do_read_from_pu;
  logic              do_write_from_pu;
  logic [WORD_W-1:0] wr_data_from_ar;
  logic              do_clear_from_pnl;
  logic [WORD_W-1:0] rd_data_to_ar;
  logic              busy_to_pu;
  logic              done_to_pu;
  logic              addr_err_to_pu;
  logic              req_err_to_pu;

  modport master (
    output sel_value_from_sel, do_read_from_pu, do_write_from_pu,
           wr_data_from_ar, do_clear_from_pnl,
    input  rd_data_to_ar, busy_to_pu, done_to_pu, addr_err_to_pu, req_err_to_pu
  );

  modport slave (
    input  sel_value_from_sel, do_read_from_pu, do_write_from_pu,
           wr_data_from_ar, do_clear_from_pnl,
    output rd_data_to_ar, busy_to_pu, done_to_pu, addr_err_to_pu, req_err_to_pu
  );

endinterface

// File: rtl/core_mem_seq_array.sv
// Core storage: synchronous read, single write port, contents survive reset.
module core_mem_array #(
  parameter int unsigned WORD_W = 31,
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned AW     = 12
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic              rd_zero,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= rd_zero ? '0 : mem[rd_addr];
  end

endmodule

// File: rtl/core_mem_seq.sv
// Main-store sequencer: destructive read / regenerate core cycle plus panel clear sweep.
module core_mem_seq
  import core_mem_seq_pkg::*;
#(
  parameter int unsigned WORD_W  = 31,
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned T_READ  = 2,
  parameter int unsigned T_WRITE = 2
) (
  input logic           clk,
  input logic           resetn,
  core_mem_seq_if.slave bus
);

  localparam int unsigned CNT_RAW = $clog2(max3(T_READ, T_WRITE, DEPTH));
  localparam int unsigned CNT_W   = (CNT_RAW > 0) ? CNT_RAW : 1;
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [WORD_W-1:0]  wr_q;
  op_t                op_q, op_d;
  logic [WORD_W-1:0]  rd_q;
  logic               rd_from_arr_q;
  logic [2:0]         req_prev_q;
  logic               req_err_q;

  logic               accept;
  logic               rd_en, we;
  logic               addr_ok;
  logic               busy;
  logic [2:0]         req_now;
  logic [WORD_W-1:0]  data_q;
  logic [AW-1:0]      wr_addr;
  logic [WORD_W-1:0]  wr_word;

  assign req_now = {bus.do_clear_from_pnl, bus.do_write_from_pu, bus.do_read_from_pu};
  assign addr_ok = 32'(addr_q) < DEPTH;
  assign busy    = (state_q == READ) || (state_q == WRITE) || (state_q == CLEAR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    accept  = 1'b0;
    rd_en   = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (|req_now) begin
          accept = 1'b1;
          cnt_d  = '0;
          if (bus.do_clear_from_pnl) begin
            state_d = CLEAR;
            op_d    = OP_CLEAR;
          end else begin
            state_d = READ;
            op_d    = bus.do_read_from_pu ? OP_READ : OP_WRITE;
          end
        end
      end
      READ: begin
        if (cnt_q == CNT_W'(T_READ - 1)) begin
          rd_en   = 1'b1;
          cnt_d   = '0;
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITE: begin
        if (cnt_q == CNT_W'(T_WRITE - 1)) begin
          we      = addr_ok;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLEAR: begin
        we = 1'b1;
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_addr = (state_q == CLEAR) ? cnt_q[AW-1:0] : addr_q[AW-1:0];
  assign wr_word = (state_q == CLEAR) ? '0 : ((op_q == OP_READ) ? data_q : wr_q);

  core_mem_array #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk     (clk),
    .rd_en   (rd_en && resetn),
    .rd_zero (!addr_ok),
    .rd_addr (addr_q[AW-1:0]),
    .rd_data (data_q),
    .we      (we && resetn),
    .wr_addr (wr_addr),
    .wr_data (wr_word)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      wr_q          <= '0;
      op_q          <= OP_READ;
      rd_q          <= '0;
      rd_from_arr_q <= 1'b0;
      req_prev_q    <= '0;
      req_err_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_prev_q <= req_now;
      req_err_q  <= (busy && |(req_now & ~req_prev_q)) ||
                    (accept && bus.do_read_from_pu && bus.do_write_from_pu);
      if (accept) begin
        addr_q <= bus.sel_value_from_sel;
        wr_q   <= bus.wr_data_from_ar;
        op_q   <= op_d;
      end
      // The array output register doubles as rd_data after a read; a write's
      // destructive read reloads it, so the last read word is parked in rd_q first.
      if (rd_en) begin
        if (op_q == OP_READ) begin
          rd_from_arr_q <= 1'b1;
        end else if (rd_from_arr_q) begin
          rd_q          <= data_q;
          rd_from_arr_q <= 1'b0;
        end
      end
    end
  end

  assign bus.rd_data_to_ar  = rd_from_arr_q ? data_q : rd_q;
  assign bus.busy_to_pu     = busy;
  assign bus.done_to_pu     = (state_q == DONE);
  assign bus.addr_err_to_pu = (state_q == DONE) && (op_q != OP_CLEAR) && !addr_ok;
  assign bus.req_err_to_pu  = req_err_q;

endmodule

// File: tb/tb_core_mem_seq.sv
// Directed bench for core_mem_seq: two instances (4096 and 16 words), scoreboarded completions.
module tb_core_mem_seq;

  localparam int W   = 31;
  localparam int T_R = 2;
  localparam int T_W = 2;
  localparam int BUDGET = 40;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  core_mem_seq_if #(.WORD_W(W)) bus_a ();
  core_mem_seq_if #(.WORD_W(W)) bus_b ();

  core_mem_seq #(.WORD_W(W), .DEPTH(4096), .T_READ(T_R), .T_WRITE(T_W)) u_a (
    .clk(clk), .resetn(resetn), .bus(bus_a));
  core_mem_seq #(.WORD_W(W), .DEPTH(16), .T_READ(T_R), .T_WRITE(T_W)) u_b (
    .clk(clk), .resetn(resetn), .bus(bus_b));

  typedef struct {
    string        tag;
    logic [W-1:0] rd;
    logic         aerr;
    logic         rerr;
    int           lat;
    int           busy_n;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] mdl [2][4096];
  logic [W-1:0] last_rd [2];
  int           total = 0;
  int           passed = 0;
  int           fails = 0;

  function automatic int dep(input int u);
    return (u == 0) ? 4096 : 16;
  endfunction

  function automatic logic [W-1:0] o_rd(input int u);
    return (u == 0) ? bus_a.rd_data_to_ar : bus_b.rd_data_to_ar;
  endfunction
  function automatic logic o_busy(input int u);
    return (u == 0) ? bus_a.busy_to_pu : bus_b.busy_to_pu;
  endfunction
  function automatic logic o_done(input int u);
    return (u == 0) ? bus_a.done_to_pu : bus_b.done_to_pu;
  endfunction
  function automatic logic o_aerr(input int u);
    return (u == 0) ? bus_a.addr_err_to_pu : bus_b.addr_err_to_pu;
  endfunction
  function automatic logic o_rerr(input int u);
    return (u == 0) ? bus_a.req_err_to_pu : bus_b.req_err_to_pu;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int u, input bit rd, input bit wr, input bit clr,
                         input logic [11:0] a, input logic [W-1:0] d);
    if (u == 0) begin
      bus_a.do_read_from_pu = rd; bus_a.do_write_from_pu = wr; bus_a.do_clear_from_pnl = clr;
      bus_a.sel_value_from_sel = a; bus_a.wr_data_from_ar = d;
    end else begin
      bus_b.do_read_from_pu = rd; bus_b.do_write_from_pu = wr; bus_b.do_clear_from_pnl = clr;
      bus_b.sel_value_from_sel = a; bus_b.wr_data_from_ar = d;
    end
  endtask

  task automatic set_wr(input int u, input bit v);
    if (u == 0) bus_a.do_write_from_pu = v;
    else        bus_b.do_write_from_pu = v;
  endtask

  task automatic push_exp(input int u, input bit rd, input bit wr, input bit clr,
                          input logic [11:0] a, input logic [W-1:0] d, input string tag);
    exp_t e;
    e.tag  = tag;
    e.rerr = rd && wr;
    if (clr) begin
      e.lat = dep(u) + 1; e.busy_n = dep(u); e.aerr = 1'b0;
      for (int i = 0; i < dep(u); i++) mdl[u][i] = '0;
    end else begin
      e.lat = T_R + T_W + 1; e.busy_n = T_R + T_W;
      e.aerr = (int'(a) >= dep(u));
      if (rd) last_rd[u] = (int'(a) < dep(u)) ? mdl[u][a] : '0;
      else if (int'(a) < dep(u)) mdl[u][a] = d;
    end
    e.rd = last_rd[u];
    sb.push_back(e);
  endtask

  task automatic wait_done(input int u, input int raise);
    exp_t e;
    int   n = 0;
    int   busy_n = 0;
    logic aerr = 1'b0;
    logic [W-1:0] rd_end = '0;
    e = sb[0];
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      if (o_busy(u)) busy_n++;
      if (c == 1) check({e.tag, "/req_err"}, 64'(o_rerr(u)), 64'(e.rerr));
      if (raise > 0 && c == raise) set_wr(u, 1'b1);
      if (raise > 0 && c == raise + 1) begin
        check({e.tag, "/busy_req_err"}, 64'(o_rerr(u)), 64'd1);
        set_wr(u, 1'b0);
      end
      if (c == T_R + 1) check({e.tag, "/rd_mid"}, 64'(o_rd(u)), 64'(e.rd));
      if (o_done(u)) begin
        n = c; aerr = o_aerr(u); rd_end = o_rd(u);
        break;
      end
    end
    e = sb.pop_front();
    check({e.tag, "/latency"}, 64'(n), 64'(e.lat));
    check({e.tag, "/busy_cycles"}, 64'(busy_n), 64'(e.busy_n));
    check({e.tag, "/rd_data"}, 64'(rd_end), 64'(e.rd));
    check({e.tag, "/addr_err"}, 64'(aerr), 64'(e.aerr));
  endtask

  task automatic run_op(input int u, input bit rd, input bit wr, input bit clr,
                        input logic [11:0] a, input logic [W-1:0] d, input logic [11:0] alt,
                        input bit hold, input int raise, input string tag);
    @(posedge clk); #1;
    set_req(u, rd, wr, clr, a, d);
    push_exp(u, rd, wr, clr, a, d, tag);
    @(posedge clk); #1;
    if (hold) begin
      if (u == 0) bus_a.sel_value_from_sel = alt; else bus_b.sel_value_from_sel = alt;
    end else begin
      set_req(u, 1'b0, 1'b0, 1'b0, alt, d);
    end
    wait_done(u, raise);
  endtask

  task automatic check_idle(input int u, input string tag);
    check({tag, "/busy"}, 64'(o_busy(u)), 64'd0);
    check({tag, "/done"}, 64'(o_done(u)), 64'd0);
    check({tag, "/rd_data"}, 64'(o_rd(u)), 64'd0);
    check({tag, "/addr_err"}, 64'(o_aerr(u)), 64'd0);
    check({tag, "/req_err"}, 64'(o_rerr(u)), 64'd0);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      last_rd[u] = '0;
      for (int i = 0; i < 4096; i++) mdl[u][i] = '0;
    end
    resetn = 1'b0;
    set_req(0, 1'b0, 1'b0, 1'b0, 12'o0, '0);
    set_req(1, 1'b0, 1'b0, 1'b0, 12'o0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle(0, "reset_a");
    check_idle(1, "reset_b");
    resetn = 1'b1;

    // write then read
    run_op(0, 0, 1, 0, 12'o0017, 31'o1234567, 12'o0017, 0, 0, "wr17");
    run_op(0, 1, 0, 0, 12'o0017, '0, 12'o0017, 0, 0, "rd17");

    // back-to-back reads with the request held through DONE
    run_op(0, 1, 0, 0, 12'o0017, '0, 12'o0017, 1, 0, "rd17_b2b1");
    push_exp(0, 1, 0, 0, 12'o0017, '0, "rd17_b2b2");
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 1'b0, 12'o0017, '0);
    wait_done(0, 0);

    // selection change during busy has no effect
    run_op(0, 0, 1, 0, 12'o7777, 31'o3333333, 12'o7777, 0, 0, "wr7777");
    run_op(0, 0, 1, 0, 12'o0017, 31'o7654321, 12'o7777, 0, 0, "wr17_selchg");
    run_op(0, 1, 0, 0, 12'o7777, '0, 12'o7777, 0, 0, "rd7777");
    run_op(0, 1, 0, 0, 12'o0017, '0, 12'o0017, 0, 0, "rd17_new");

    // conflicting read+write, then a write raised mid-busy
    run_op(0, 0, 1, 0, 12'o0005, 31'o55555, 12'o0005, 0, 0, "wr5");
    run_op(0, 1, 1, 0, 12'o0005, 31'o11111, 12'o0005, 0, 0, "rdwr5");
    run_op(0, 1, 0, 0, 12'o0005, '0, 12'o0005, 0, 2, "rd5_raise");
    run_op(0, 1, 0, 0, 12'o0005, '0, 12'o0005, 0, 0, "rd5_again");

    // unimplemented addresses on the 16-word store
    run_op(1, 0, 1, 0, 12'o0000, 31'o123, 12'o0000, 0, 0, "b_wr0");
    run_op(1, 0, 1, 0, 12'o0017, 31'o1515, 12'o0017, 0, 0, "b_wr15");
    run_op(1, 1, 0, 0, 12'o0017, '0, 12'o0017, 0, 0, "b_rd15");
    run_op(1, 1, 0, 0, 12'o0020, '0, 12'o0020, 0, 0, "b_rd16");
    run_op(1, 1, 0, 0, 12'o4000, '0, 12'o4000, 0, 0, "b_rd4000");
    run_op(1, 0, 1, 0, 12'o4000, 31'o7777777, 12'o4000, 0, 0, "b_wr4000");
    run_op(1, 1, 0, 0, 12'o0000, '0, 12'o0000, 0, 0, "b_rd0");

    // fill, panel clear, verify
    for (int i = 0; i < 4; i++)
      run_op(1, 0, 1, 0, 12'(i), 31'(32'o100 + i), 12'(i), 0, 0, "b_fill");
    run_op(1, 1, 0, 0, 12'o0002, '0, 12'o0002, 0, 0, "b_rd2_pre");
    run_op(1, 0, 0, 1, 12'o0000, '0, 12'o0000, 0, 0, "b_clear");
    for (int i = 0; i < 4; i++)
      run_op(1, 1, 0, 0, 12'(i), '0, 12'(i), 0, 0, "b_rd_cleared");
    run_op(1, 1, 0, 0, 12'o0017, '0, 12'o0017, 0, 0, "b_rd15_cleared");

    // reset in the final WRITE cycle aborts the store update
    run_op(0, 0, 1, 0, 12'o0100, 31'o2222222, 12'o0100, 0, 0, "wr100_old");
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b1, 1'b0, 12'o0100, 31'o4444444);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 1'b0, 12'o0100, 31'o4444444);
    repeat (T_R + T_W) @(negedge clk);
    check("rst_mid/busy_before", 64'(o_busy(0)), 64'd1);
    resetn = 1'b0;
    @(negedge clk);
    check_idle(0, "rst_mid");
    resetn = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    run_op(0, 1, 0, 0, 12'o0100, '0, 12'o0100, 0, 0, "rd100_after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/core_mem_seq.md
Name: core_mem_seq

Overview:
Ferrite-core main store sequencer; the consumer of the selection register's 12-bit address output. Accepts read/write requests from the control unit (PU), latches the selected address and the write word, and runs a destructive-read / regenerate core cycle with fixed phase timing. Also performs a panel-initiated whole-store clear sweep. Holds the storage array internally.

Parameters:
WORD_W, 31, storage word width in bits
DEPTH, 4096, number of implemented words (1..4096); addresses >= DEPTH are unimplemented
T_READ, 2, cycles in READ phase (>=1)
T_WRITE, 2, cycles in REGEN/WRITE phase (>=1)

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
sel_value_from_sel  in  12  address from selection register
do_read_from_pu  in  1  read request, level sampled when not busy
do_write_from_pu  in  1  write request, level sampled when not busy
wr_data_from_ar  in  WORD_W  word to store
do_clear_from_pnl  in  1  panel store-clear request
rd_data_to_ar  out  WORD_W  last word read
busy_to_pu  out  1  access or sweep in progress
done_to_pu  out  1  one-cycle completion pulse
addr_err_to_pu  out  1  one-cycle pulse with done when address unimplemented
req_err_to_pu  out  1  one-cycle pulse on dropped/conflicting request

Behaviour:
- States: IDLE, READ, WRITE, CLEAR, DONE. Phase counter width clog2(max(T_READ,T_WRITE,DEPTH)).
- Reset: state IDLE, busy 0, done 0, both err 0, rd_data 0, counters 0. Storage array NOT cleared. Reset mid-cycle aborts; no store write happens on the reset edge.
- Acceptance (IDLE or DONE, at edge): priority clear > read > write. Latch addr_q <= sel_value_from_sel, wr_q <= wr_data_from_ar, op_q. Later changes of the selection register have no effect on the access in flight.
- Read and write both high at acceptance: read performed, write dropped, req_err pulses in cycle after acceptance.
- Any request asserted while busy (READ/WRITE/CLEAR): ignored; req_err pulses one cycle per cycle of assertion of a new rising edge of that request (edge-detected, registered).
- READ: T_READ cycles. On final READ edge: data_q <= mem[addr_q] (0 if addr_q >= DEPTH). For reads rd_data_to_ar <= same value on that edge; for writes rd_data unchanged.
- WRITE: T_WRITE cycles. On final edge: mem[addr_q] <= (read ? data_q : wr_q) when addr_q < DEPTH; otherwise no store write.
- DONE: exactly one cycle; done=1, busy=0; addr_err=1 iff addr_q >= DEPTH. Requests sampled here are accepted as in IDLE (back-to-back). Then IDLE if none.
- Latency: request sampled at edge 0 -> busy high in cycles 1..T_READ+T_WRITE -> done in cycle T_READ+T_WRITE+1 (5 with defaults).
- CLEAR: sweep counter 0..DEPTH-1, one word zeroed per cycle, busy high DEPTH cycles, then DONE (addr_err 0). rd_data unchanged.
- Single-port storage: at most one array read and one write per edge; synchronous read.

Decomposition:
- Shared package: state enum (IDLE/READ/WRITE/CLEAR/DONE), op encoding (OP_READ/OP_WRITE/OP_CLEAR), 12-bit address width constant shared with selection register.
- One sub-module: core_mem_array (WORD_W x DEPTH storage, sync read, single write port, no reset).

Test Plan:
- Write 0o1234567 at addr 0o0017, then read 0o0017 -> each done at cycle 5 after request; rd_data = 0o1234567 from read's cycle 3 onward.
- Read 0o0017 twice back-to-back (request held through DONE) -> both return 0o1234567 (regeneration verified); second done 5 cycles after first.
- Change sel_value to 0o7777 during busy after latching 0o0017 -> access uses 0o0017; addr 0o7777 contents unchanged.
- DEPTH=2048, read addr 0o4000 -> done cycle 5 with addr_err=1, rd_data=0; write addr 0o4000 then read 0o0000 -> 0o0000 unaffected.
- Simultaneous read+write at addr 5 -> read performed, req_err pulse, mem[5] unchanged; write request raised mid-busy -> req_err pulse, ignored.
- Fill addrs 0..3 nonzero, panel clear (DEPTH=16) -> busy 16 cycles, done; all reads return 0; resetn low mid-write -> IDLE next cycle, target word retains old value.
